// File: rtl/jms_pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | jms_pipe_pkg : shared constants, sizing helpers and stage record type     |
// | Optional feature macro: JMS_PIPE_PARITY_EN                                |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package jms_pipe_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

`ifdef JMS_PIPE_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int stage_bits(input int width);
        return 1 + PAR_BITS + width;
    endfunction

    typedef struct packed {
        logic                 valid;
`ifdef JMS_PIPE_PARITY_EN
        logic                 parity;
`endif
        logic [DEF_WIDTH-1:0] data;
    } stage_def_t;

endpackage
`default_nettype wire

// File: rtl/jms_pipe_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | jms_pipe_if : valid/ready upstream + downstream bundle of the pipeline    |
// | Optional feature macro: JMS_PIPE_PARITY_EN (adds parityErr)               |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface jms_pipe_if #(
    parameter int WIDTH = jms_pipe_pkg::DEF_WIDTH,
    parameter int DEPTH = jms_pipe_pkg::DEF_DEPTH
);
    import jms_pipe_pkg::*;

    logic                          inValid;
    logic                          inReady;
    logic [WIDTH-1:0]              inData;
    logic                          outValid;
    logic                          outReady;
    logic [WIDTH-1:0]              outData;
    logic [occ_width(DEPTH)-1:0]   occupancy;
`ifdef JMS_PIPE_PARITY_EN
    logic                          parityErr;
`endif

    modport master (
        output inValid,
        output inData,
        output outReady,
`ifdef JMS_PIPE_PARITY_EN
        input  parityErr,
`endif
        input  inReady,
        input  outValid,
        input  outData,
        input  occupancy
    );

    modport slave (
        input  inValid,
        input  inData,
        input  outReady,
`ifdef JMS_PIPE_PARITY_EN
        output parityErr,
`endif
        output inReady,
        output outValid,
        output outData,
        output occupancy
    );

endinterface
`default_nettype wire

// File: rtl/jms_pipe_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | jms_pipe_stage : one elastic stage (valid, data, optional parity)         |
// | Optional feature macro: JMS_PIPE_PARITY_EN                                |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module jms_pipe_stage
    import jms_pipe_pkg::*;
#(
    parameter int               WIDTH    = DEF_WIDTH,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  wire logic             clk,
    input  wire logic             rstN,
    input  wire logic             flush_i,
    input  wire logic             load_i,
    input  wire logic             valid_i,
    input  wire logic [WIDTH-1:0] data_i,
`ifdef JMS_PIPE_PARITY_EN
    input  wire logic             parity_i,
    output logic                  parity_o,
`endif
    output logic                  valid_o,
    output logic [WIDTH-1:0]      data_o
);

    typedef struct packed {
        logic             valid;
`ifdef JMS_PIPE_PARITY_EN
        logic             parity;
`endif
        logic [WIDTH-1:0] data;
    } stage_t;

    stage_t stage_q;
    stage_t stage_d;

    // Flush clears only the valid bit; payload registers keep their contents.
    always_comb begin
        stage_d = stage_q;
        if (flush_i) begin
            stage_d.valid = 1'b0;
        end else if (load_i) begin
            stage_d.valid  = valid_i;
            stage_d.data   = data_i;
`ifdef JMS_PIPE_PARITY_EN
            stage_d.parity = parity_i;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            stage_q.valid  <= 1'b0;
            stage_q.data   <= INIT_VAL;
`ifdef JMS_PIPE_PARITY_EN
            stage_q.parity <= ^INIT_VAL;
`endif
        end else begin
            stage_q <= stage_d;
        end
    end

    assign valid_o  = stage_q.valid;
    assign data_o   = stage_q.data;
`ifdef JMS_PIPE_PARITY_EN
    assign parity_o = stage_q.parity;
`endif

endmodule
`default_nettype wire

// File: rtl/jms_pipe_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | jms_pipe_reg : DEPTH-stage elastic register pipeline, bubble collapsing,  |
// | flush and occupancy count. Optional macro: JMS_PIPE_PARITY_EN. Rev 1.0    |
// +--------------------------------------------------------------------------+
module jms_pipe_reg
    import jms_pipe_pkg::*;
#(
    parameter int          WIDTH   = DEF_WIDTH,
    parameter int          DEPTH   = DEF_DEPTH,
    parameter int unsigned INITIAL = 0
) (
    input  wire logic  clk,
    input  wire logic  rstN,
    input  wire logic  flush,
    jms_pipe_if.slave  bus
);

    localparam int               c_occ_w = occ_width(DEPTH);
    localparam logic [WIDTH-1:0] c_init  = WIDTH'(INITIAL);

    logic [DEPTH-1:0]   w_v;
    logic [WIDTH-1:0]   w_d [DEPTH];
    logic [DEPTH:0]     w_rdy;
    logic               w_accept;
    logic               w_emit;
    logic [c_occ_w-1:0] occ_q;
    logic [c_occ_w-1:0] occ_d;
`ifdef JMS_PIPE_PARITY_EN
    logic [DEPTH-1:0]   w_p;
    logic               parity_err_q;
`endif

    // An empty stage is always ready, so bubbles never stall upstream.
    always_comb begin
        w_rdy        = '0;
        w_rdy[DEPTH] = bus.outReady;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_rdy[i] = ~w_v[i] | w_rdy[i+1];
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic             w_vin;
        logic [WIDTH-1:0] w_din;
`ifdef JMS_PIPE_PARITY_EN
        logic             w_pin;
`endif
        if (gi == 0) begin : g_head
            assign w_vin = bus.inValid;
            assign w_din = bus.inData;
`ifdef JMS_PIPE_PARITY_EN
            assign w_pin = ^bus.inData;
`endif
        end else begin : g_body
            assign w_vin = w_v[gi-1];
            assign w_din = w_d[gi-1];
`ifdef JMS_PIPE_PARITY_EN
            assign w_pin = w_p[gi-1];
`endif
        end

        jms_pipe_stage #(
            .WIDTH    (WIDTH),
            .INIT_VAL (c_init)
        ) u_stage (
            .clk      (clk),
            .rstN     (rstN),
            .flush_i  (flush),
            .load_i   (w_rdy[gi]),
            .valid_i  (w_vin),
            .data_i   (w_din),
`ifdef JMS_PIPE_PARITY_EN
            .parity_i (w_pin),
            .parity_o (w_p[gi]),
`endif
            .valid_o  (w_v[gi]),
            .data_o   (w_d[gi])
        );
    end

    assign w_accept = bus.inValid & w_rdy[0];
    assign w_emit   = w_v[DEPTH-1] & bus.outReady;

    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (w_accept && !w_emit) begin
            occ_d = occ_q + c_occ_w'(1);
        end else if (w_emit && !w_accept) begin
            occ_d = occ_q - c_occ_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

`ifdef JMS_PIPE_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rstN) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= w_emit & ~flush & ((^w_d[DEPTH-1]) != w_p[DEPTH-1]);
        end
    end

    assign bus.parityErr = parity_err_q;
`endif

    assign bus.inReady   = w_rdy[0];
    assign bus.outValid  = w_v[DEPTH-1];
    assign bus.outData   = w_d[DEPTH-1];
    assign bus.occupancy = occ_q;

endmodule
`default_nettype wire

// File: tb/tb_jms_pipe_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_jms_pipe_reg : directed self-checking bench for jms_pipe_reg           |
// | Optional macro: JMS_PIPE_PARITY_EN enables the parity steps. Rev 1.0      |
// +--------------------------------------------------------------------------+
module tb_jms_pipe_reg;

    logic clk;
    logic rstN;
    logic flush;

    int checks   = 0;
    int failures = 0;
    int n_emit   = 0;
    logic [7:0] exp_q [$];

    jms_pipe_if #(.WIDTH(8), .DEPTH(4)) bus ();

    jms_pipe_reg #(
        .WIDTH   (8),
        .DEPTH   (4),
        .INITIAL (32'hA5)
    ) dut (
        .clk   (clk),
        .rstN  (rstN),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: score the handshake seen before the edge, then step past it.
    task automatic cyc(output bit acc);
        #1;
        acc = 1'b0;
        if (!rstN || flush) begin
            exp_q.delete();
        end else begin
            if (bus.outValid && bus.outReady) begin
                if (exp_q.size() == 0) begin
                    check("emit_unexpected", 32'(exp_q.size()), 32'd1);
                end else begin
                    check("emit_data", 32'(bus.outData), 32'(exp_q.pop_front()));
                    n_emit++;
                end
            end
            if (bus.inValid && bus.inReady) begin
                exp_q.push_back(bus.inData);
                acc = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] w);
        bit acc;
        int n;
        bus.inValid = 1'b1;
        bus.inData  = w;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            cyc(acc);
            n++;
        end
        check("send_accepted", 32'(acc), 32'd1);
    endtask

    task automatic drain();
        bit acc;
        int n;
        bus.inValid = 1'b0;
        n = 0;
        while (bus.occupancy != 0 && n < 50) begin
            cyc(acc);
            n++;
        end
        cyc(acc);
        check("drain_occ", 32'(bus.occupancy), 32'd0);
    endtask

    initial begin
        bit acc;
        int e0;

        rstN         = 1'b0;
        flush        = 1'b0;
        bus.inValid  = 1'b0;
        bus.inData   = 8'h00;
        bus.outReady = 1'b0;

        // Reset held for two edges.
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_outValid",  32'(bus.outValid),  32'd0);
        check("rst_outData",   32'(bus.outData),   32'hA5);
        check("rst_occupancy", 32'(bus.occupancy), 32'd0);
        check("rst_inReady",   32'(bus.inReady),   32'd1);
        rstN = 1'b1;

        // Latency through an empty pipe.
        bus.outReady = 1'b1;
        bus.inValid  = 1'b1;
        bus.inData   = 8'h3C;
        cyc(acc);
        check("lat_accept", 32'(acc), 32'd1);
        bus.inValid = 1'b0;
        check("lat_occ_e0",   32'(bus.occupancy), 32'd1);
        check("lat_valid_e0", 32'(bus.outValid),  32'd0);
        cyc(acc);
        cyc(acc);
        check("lat_valid_e2", 32'(bus.outValid),  32'd0);
        cyc(acc);
        check("lat_valid_e3", 32'(bus.outValid),  32'd1);
        check("lat_data_e3",  32'(bus.outData),   32'h3C);
        check("lat_occ_e3",   32'(bus.occupancy), 32'd1);
        cyc(acc);
        check("lat_valid_e4", 32'(bus.outValid),  32'd0);
        check("lat_occ_e4",   32'(bus.occupancy), 32'd0);

        // Back-to-back streaming.
        e0 = n_emit;
        for (int k = 1; k <= 16; k++) begin
            bus.inValid = 1'b1;
            bus.inData  = 8'(k);
            #1;
            check("stream_inReady", 32'(bus.inReady), 32'd1);
            cyc(acc);
            check("stream_accept", 32'(acc), 32'd1);
            check("stream_occ", 32'(bus.occupancy), (k < 4) ? 32'(k) : 32'd4);
        end
        drain();
        check("stream_count", 32'(n_emit - e0), 32'd16);

        // Backpressure: four fit, the fifth waits.
        e0 = n_emit;
        bus.outReady = 1'b0;
        send(8'h21);
        send(8'h22);
        send(8'h23);
        send(8'h24);
        bus.inValid = 1'b1;
        bus.inData  = 8'h25;
        cyc(acc);
        check("bp_blocked0", 32'(acc), 32'd0);
        check("bp_inReady",  32'(bus.inReady),   32'd0);
        check("bp_occ",      32'(bus.occupancy), 32'd4);
        cyc(acc);
        check("bp_blocked1", 32'(acc), 32'd0);
        bus.outReady = 1'b1;
        send(8'h25);
        send(8'h26);
        drain();
        check("bp_count", 32'(n_emit - e0), 32'd6);

        // Flush with an accept pending; stage data stays at the drained 0x26.
        bus.outReady = 1'b0;
        send(8'h31);
        send(8'h32);
        send(8'h33);
        check("fl_occ_pre", 32'(bus.occupancy), 32'd3);
        flush       = 1'b1;
        bus.inValid = 1'b1;
        bus.inData  = 8'h3F;
        cyc(acc);
        flush       = 1'b0;
        bus.inValid = 1'b0;
        check("fl_occ",      32'(bus.occupancy), 32'd0);
        check("fl_outValid", 32'(bus.outValid),  32'd0);
        check("fl_data_kept", 32'(bus.outData),  32'h26);
        bus.outReady = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc(acc);
            check("fl_no_output", 32'(bus.outValid), 32'd0);
        end
        bus.inValid = 1'b1;
        bus.inData  = 8'h44;
        cyc(acc);
        bus.inValid = 1'b0;
        cyc(acc);
        cyc(acc);
        check("fl_lat_e2", 32'(bus.outValid), 32'd0);
        cyc(acc);
        check("fl_lat_e3",  32'(bus.outValid), 32'd1);
        check("fl_lat_dat", 32'(bus.outData),  32'h44);
        cyc(acc);
        check("fl_lat_occ", 32'(bus.occupancy), 32'd0);

        // Reset mid-stream discards in-flight words.
        bus.outReady = 1'b0;
        send(8'h51);
        send(8'h52);
        bus.inValid = 1'b0;
        rstN = 1'b0;
        cyc(acc);
        rstN = 1'b1;
        check("mrst_outValid", 32'(bus.outValid),  32'd0);
        check("mrst_occ",      32'(bus.occupancy), 32'd0);
        check("mrst_outData",  32'(bus.outData),   32'hA5);
        check("mrst_inReady",  32'(bus.inReady),   32'd1);
        bus.outReady = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc(acc);
            check("mrst_no_output", 32'(bus.outValid), 32'd0);
        end

`ifdef JMS_PIPE_PARITY_EN
        // Corrupt one bit of a word while it sits in stage 2.
        bus.outReady = 1'b1;
        send(8'h12);
        bus.inValid = 1'b0;
        check("par_e0", 32'(bus.parityErr), 32'd0);
        cyc(acc);
        cyc(acc);
        dut.g_stage[2].u_stage.stage_q.data[0] = ~dut.g_stage[2].u_stage.stage_q.data[0];
        exp_q[0] = exp_q[0] ^ 8'h01;
        check("par_e2", 32'(bus.parityErr), 32'd0);
        cyc(acc);
        check("par_e3", 32'(bus.parityErr), 32'd0);
        cyc(acc);
        check("par_err_hit", 32'(bus.parityErr), 32'd1);
        cyc(acc);
        check("par_err_clear", 32'(bus.parityErr), 32'd0);
        send(8'h34);
        bus.inValid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cyc(acc);
            check("par_clean", 32'(bus.parityErr), 32'd0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
